// File: rtl/lc3_pkg.sv
// Shared definitions for the LC-3 memory access datapath: access FSM state
// encoding, the memory-mapped switch address and the wait counter width.
package lc3_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR_WAIT = 2'd2,
    DONE    = 2'd3
  } mem_state_t;

  // Reads from this address return the board switches when MMIO_SW_EN is built in
  localparam logic [15:0] MMIO_SW_ADDR = 16'hFFFF;

  // Wide enough for WAIT_CYCLES-1 with WAIT_CYCLES up to 15
  localparam int unsigned CNT_W = 4;

endpackage

// File: rtl/mem_wait_counter.sv
// Loadable down-counter with zero flag; paces SRAM wait states.
// Decrement saturates at zero so an idle counter stays parked.
module mem_wait_counter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic [WIDTH-1:0] count,
  output logic             zero
);

  // Load has priority over decrement; reset clears the count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - WIDTH'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/mem_access_unit.sv
// LC-3 memory access unit: MAR/MDR registers and an SRAM access sequencer
// with WAIT_CYCLES wait states per access. All FSM outputs are registered.
// Optional build macro MMIO_SW_EN adds an SW port; reads at 16'hFFFF then
// return SW into MDR and leave the SRAM strobes low, with unchanged timing.
module mem_access_unit
  import lc3_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [15:0] Bus_In,
  input  logic        LD_MAR,
  input  logic        LD_MDR,
  input  logic        Mem_Req,
  input  logic        Mem_WE,
  input  logic [15:0] Data_from_SRAM,
`ifdef MMIO_SW_EN
  input  logic [15:0] SW,
`endif
  output logic [15:0] MAR,
  output logic [15:0] MDR,
  output logic [15:0] SRAM_ADDR,
  output logic [15:0] Data_to_SRAM,
  output logic        SRAM_CE,
  output logic        SRAM_OE,
  output logic        SRAM_WE,
  output logic        Mem_Busy,
  output logic        Mem_Done
);

  localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_CYCLES - 1);

  mem_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic             cnt_zero;
  logic             cnt_load;
  logic             cnt_dec;
  logic             accept;
  logic             in_wait;
  logic             mmio_hit;
  logic [15:0]      rd_data;
  logic             mar_pend;
  logic [15:0]      mar_pend_val;

  assign accept   = (state == IDLE) && Mem_Req;
  assign in_wait  = (state == RD_WAIT) || (state == WR_WAIT);
  assign cnt_load = accept;
  assign cnt_dec  = in_wait;

`ifdef MMIO_SW_EN
  logic mmio_acc;

  assign mmio_hit = (MAR == MMIO_SW_ADDR) && !Mem_WE;
  assign rd_data  = mmio_acc ? SW : Data_from_SRAM;

  // Remember whether the accepted read targets the switch register
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      mmio_acc <= 1'b0;
    end else if (accept) begin
      mmio_acc <= mmio_hit;
    end
  end
`else
  assign mmio_hit = 1'b0;
  assign rd_data  = Data_from_SRAM;
`endif

  mem_wait_counter #(
    .WIDTH(CNT_W)
  ) u_wait_counter (
    .clk      (Clk),
    .rst      (Reset),
    .load     (cnt_load),
    .load_val (WAIT_LOAD),
    .dec      (cnt_dec),
    .count    (cnt),
    .zero     (cnt_zero)
  );

  // Access sequencer with registered strobes, busy and done
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state    <= IDLE;
      SRAM_CE  <= 1'b0;
      SRAM_OE  <= 1'b0;
      SRAM_WE  <= 1'b0;
      Mem_Busy <= 1'b0;
      Mem_Done <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          Mem_Done <= 1'b0;
          if (Mem_Req) begin
            state    <= Mem_WE ? WR_WAIT : RD_WAIT;
            SRAM_CE  <= !mmio_hit;
            SRAM_OE  <= !Mem_WE && !mmio_hit;
            SRAM_WE  <= Mem_WE;
            Mem_Busy <= 1'b1;
          end
        end
        RD_WAIT, WR_WAIT: begin
          if (cnt_zero) begin
            state    <= DONE;
            SRAM_CE  <= 1'b0;
            SRAM_OE  <= 1'b0;
            SRAM_WE  <= 1'b0;
            Mem_Busy <= 1'b0;
            Mem_Done <= 1'b1;
          end
        end
        DONE: begin
          state    <= IDLE;
          Mem_Done <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          SRAM_CE  <= 1'b0;
          SRAM_OE  <= 1'b0;
          SRAM_WE  <= 1'b0;
          Mem_Busy <= 1'b0;
          Mem_Done <= 1'b0;
        end
      endcase
    end
  end

  // MAR load; a load coinciding with an accepted request is parked until
  // the access finishes so the SRAM address stays on the old MAR.
  // A fresh LD_MAR in DONE supersedes the parked value.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      MAR          <= '0;
      mar_pend     <= 1'b0;
      mar_pend_val <= '0;
    end else if (LD_MAR && !Mem_Busy) begin
      if (accept) begin
        mar_pend     <= 1'b1;
        mar_pend_val <= Bus_In;
      end else begin
        MAR      <= Bus_In;
        mar_pend <= 1'b0;
      end
    end else if (mar_pend && (state == DONE)) begin
      MAR      <= mar_pend_val;
      mar_pend <= 1'b0;
    end
  end

  // MDR load from bus when idle, capture of read data on the last read wait cycle
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      MDR <= '0;
    end else if ((state == RD_WAIT) && cnt_zero) begin
      MDR <= rd_data;
    end else if (LD_MDR && !Mem_Busy) begin
      MDR <= Bus_In;
    end
  end

  assign SRAM_ADDR    = MAR;
  assign Data_to_SRAM = MDR;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit with a scoreboard of expected
// access results. Define MMIO_SW_EN to also exercise the switch register.
module tb_mem_access_unit;

  localparam int unsigned W = 2;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [15:0] Bus_In;
  logic        LD_MAR, LD_MDR, Mem_Req, Mem_WE;
  logic [15:0] Data_from_SRAM;
`ifdef MMIO_SW_EN
  logic [15:0] SW;
`endif
  logic [15:0] MAR, MDR, SRAM_ADDR, Data_to_SRAM;
  logic        SRAM_CE, SRAM_OE, SRAM_WE, Mem_Busy, Mem_Done;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [15:0] addr;
    logic [15:0] mdr;
    int          lat;
    int          ce;
    int          oe;
    int          we;
  } exp_t;

  exp_t sb[$];

  mem_access_unit #(.WAIT_CYCLES(W)) dut (
    .Clk            (Clk),
    .Reset          (Reset),
    .Bus_In         (Bus_In),
    .LD_MAR         (LD_MAR),
    .LD_MDR         (LD_MDR),
    .Mem_Req        (Mem_Req),
    .Mem_WE         (Mem_WE),
    .Data_from_SRAM (Data_from_SRAM),
`ifdef MMIO_SW_EN
    .SW             (SW),
`endif
    .MAR            (MAR),
    .MDR            (MDR),
    .SRAM_ADDR      (SRAM_ADDR),
    .Data_to_SRAM   (Data_to_SRAM),
    .SRAM_CE        (SRAM_CE),
    .SRAM_OE        (SRAM_OE),
    .SRAM_WE        (SRAM_WE),
    .Mem_Busy       (Mem_Busy),
    .Mem_Done       (Mem_Done)
  );

  always #5 Clk = ~Clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic load_mar(input logic [15:0] v);
    @(negedge Clk); LD_MAR = 1'b1; Bus_In = v;
    @(negedge Clk); LD_MAR = 1'b0;
  endtask

  task automatic load_mdr(input logic [15:0] v);
    @(negedge Clk); LD_MDR = 1'b1; Bus_In = v;
    @(negedge Clk); LD_MDR = 1'b0;
  endtask

  // Drives one request and observes it up to the Mem_Done cycle (returns in DONE)
  task automatic run_access(input logic we, input logic ld_with_req, input logic [15:0] req_mar,
                            input logic ld_mid, input logic [15:0] mid_mar,
                            output int lat, output int ce_n, output int oe_n, output int we_n,
                            output logic [15:0] addr_seen, output logic [15:0] data_seen,
                            output logic addr_ok, output logic timeout);
    @(negedge Clk);
    Mem_Req = 1'b1; Mem_WE = we;
    if (ld_with_req) begin LD_MAR = 1'b1; Bus_In = req_mar; end
    @(posedge Clk); #1;
    Mem_Req = 1'b0; LD_MAR = 1'b0;
    lat = 0; ce_n = 0; oe_n = 0; we_n = 0; timeout = 1'b1; addr_ok = 1'b1;
    addr_seen = SRAM_ADDR; data_seen = Data_to_SRAM;
    for (int c = 1; c <= 64; c++) begin
      if (Mem_Done) begin lat = c; timeout = 1'b0; break; end
      if (SRAM_CE) ce_n++;
      if (SRAM_OE) oe_n++;
      if (SRAM_WE) we_n++;
      if (SRAM_ADDR !== addr_seen) addr_ok = 1'b0;
      if (ld_mid && c == 1) begin LD_MAR = 1'b1; Bus_In = mid_mar; end
      else LD_MAR = 1'b0;
      @(posedge Clk); #1;
    end
    LD_MAR = 1'b0;
  endtask

  // Runs an access and compares it with the oldest scoreboard entry
  task automatic access_and_score(input string name, input logic we, input logic ld_with_req,
                                  input logic [15:0] req_mar, input logic ld_mid,
                                  input logic [15:0] mid_mar);
    int lat, ce_n, oe_n, we_n;
    logic [15:0] a, d;
    logic aok, to;
    exp_t e;
    run_access(we, ld_with_req, req_mar, ld_mid, mid_mar, lat, ce_n, oe_n, we_n, a, d, aok, to);
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL %s_timeout: no Mem_Done within bound", name); end
    checks++; if (sb.size() == 0) begin errors++; $display("FAIL %s_sb: scoreboard empty got 0 entries exp 1", name); end
    else begin
      e = sb.pop_front();
      checks++; if (lat !== e.lat) begin errors++; $display("FAIL %s_latency: got %0d exp %0d", name, lat, e.lat); end
      checks++; if (ce_n !== e.ce) begin errors++; $display("FAIL %s_ce_cycles: got %0d exp %0d", name, ce_n, e.ce); end
      checks++; if (oe_n !== e.oe) begin errors++; $display("FAIL %s_oe_cycles: got %0d exp %0d", name, oe_n, e.oe); end
      checks++; if (we_n !== e.we) begin errors++; $display("FAIL %s_we_cycles: got %0d exp %0d", name, we_n, e.we); end
      checks++; if (a !== e.addr) begin errors++; $display("FAIL %s_addr: got %h exp %h", name, a, e.addr); end
      checks++; if (aok !== 1'b1) begin errors++; $display("FAIL %s_addr_stable: got %b exp 1", name, aok); end
      checks++; if (MDR !== e.mdr) begin errors++; $display("FAIL %s_mdr: got %h exp %h", name, MDR, e.mdr); end
      if (we) begin
        checks++; if (d !== e.mdr) begin errors++; $display("FAIL %s_wdata: got %h exp %h", name, d, e.mdr); end
      end
    end
  endtask

  task automatic push_exp(input logic [15:0] addr, input logic [15:0] mdr,
                          input int ce, input int oe, input int we);
    exp_t e;
    e.addr = addr; e.mdr = mdr; e.lat = W + 1; e.ce = ce; e.oe = oe; e.we = we;
    sb.push_back(e);
  endtask

  task automatic test_reset;
    Reset = 1'b1; Bus_In = '0; LD_MAR = 0; LD_MDR = 0; Mem_Req = 0; Mem_WE = 0;
    Data_from_SRAM = '0;
`ifdef MMIO_SW_EN
    SW = '0;
`endif
    repeat (3) @(posedge Clk);
    #1;
    checks++; if (MAR !== 16'h0) begin errors++; $display("FAIL reset_mar: got %h exp 0000", MAR); end
    checks++; if (MDR !== 16'h0) begin errors++; $display("FAIL reset_mdr: got %h exp 0000", MDR); end
    checks++; if ({SRAM_CE, SRAM_OE, SRAM_WE} !== 3'b000) begin errors++; $display("FAIL reset_strobes: got %b exp 000", {SRAM_CE, SRAM_OE, SRAM_WE}); end
    checks++; if ({Mem_Busy, Mem_Done} !== 2'b00) begin errors++; $display("FAIL reset_busy_done: got %b exp 00", {Mem_Busy, Mem_Done}); end
    @(negedge Clk); Reset = 1'b0;
  endtask

  task automatic test_read;
    load_mar(16'h3000);
    Data_from_SRAM = 16'h1234;
    push_exp(16'h3000, 16'h1234, W, W, 0);
    access_and_score("read", 1'b0, 1'b0, '0, 1'b0, '0);
    @(posedge Clk); #1;
    checks++; if (Mem_Done !== 1'b0) begin errors++; $display("FAIL read_done_pulse: got %b exp 0", Mem_Done); end
  endtask

  task automatic test_write;
    load_mar(16'h0040);
    load_mdr(16'hABCD);
    Data_from_SRAM = 16'h9999;
    push_exp(16'h0040, 16'hABCD, W, 0, W);
    access_and_score("write", 1'b1, 1'b0, '0, 1'b0, '0);
  endtask

  task automatic test_busy_ldmar;
    load_mar(16'h3000);
    Data_from_SRAM = 16'h2222;
    push_exp(16'h3000, 16'h2222, W, W, 0);
    access_and_score("busy_ldmar", 1'b0, 1'b0, '0, 1'b1, 16'h5555);
    checks++; if (MAR !== 16'h3000) begin errors++; $display("FAIL busy_ldmar_mar: got %h exp 3000", MAR); end
    @(posedge Clk); #1;
    checks++; if (MAR !== 16'h3000) begin errors++; $display("FAIL busy_ldmar_mar_after: got %h exp 3000", MAR); end
    Data_from_SRAM = 16'h3333;
    push_exp(16'h3000, 16'h3333, W, W, 0);
    access_and_score("ldmar_with_req", 1'b0, 1'b1, 16'h7777, 1'b0, '0);
    @(posedge Clk); #1;
    checks++; if (MAR !== 16'h7777) begin errors++; $display("FAIL ldmar_with_req_after: got %h exp 7777", MAR); end
  endtask

  task automatic test_done_ignores_req;
    load_mar(16'h0100);
    Data_from_SRAM = 16'h0BAD;
    push_exp(16'h0100, 16'h0BAD, W, W, 0);
    access_and_score("done_req", 1'b0, 1'b0, '0, 1'b0, '0);
    Mem_Req = 1'b1; Mem_WE = 1'b0;
    @(posedge Clk); #1;
    Mem_Req = 1'b0;
    checks++; if (Mem_Busy !== 1'b0) begin errors++; $display("FAIL done_req_busy: got %b exp 0", Mem_Busy); end
    @(posedge Clk); #1;
    checks++; if ({SRAM_CE, Mem_Busy, Mem_Done} !== 3'b000) begin errors++; $display("FAIL done_req_idle: got %b exp 000", {SRAM_CE, Mem_Busy, Mem_Done}); end
  endtask

  task automatic test_back_to_back;
    logic [15:0] a, d;
    for (int i = 0; i < 6; i++) begin
      a = 16'($urandom_range(16'h0000, 16'hFFFE));
      d = 16'($urandom);
      load_mar(a);
      if (i % 3 == 2) begin
        load_mdr(d);
        push_exp(a, d, W, 0, W);
        access_and_score("b2b_write", 1'b1, 1'b0, '0, 1'b0, '0);
      end else begin
        Data_from_SRAM = d;
        push_exp(a, d, W, W, 0);
        access_and_score("b2b_read", 1'b0, 1'b0, '0, 1'b0, '0);
      end
    end
  endtask

  task automatic test_reset_mid;
    bit seen_done;
    load_mar(16'h1111);
    load_mdr(16'h9999);
    Data_from_SRAM = 16'h4444;
    @(negedge Clk); Mem_Req = 1'b1; Mem_WE = 1'b0;
    @(posedge Clk); #1; Mem_Req = 1'b0;
    checks++; if (SRAM_OE !== 1'b1) begin errors++; $display("FAIL rst_mid_inflight: got oe=%b exp 1", SRAM_OE); end
    #1; Reset = 1'b1; #1;
    checks++; if (MAR !== 16'h0) begin errors++; $display("FAIL rst_mid_mar: got %h exp 0000", MAR); end
    checks++; if (MDR !== 16'h0) begin errors++; $display("FAIL rst_mid_mdr: got %h exp 0000", MDR); end
    checks++; if ({SRAM_CE, SRAM_OE, SRAM_WE, Mem_Busy} !== 4'b0000) begin errors++; $display("FAIL rst_mid_strobes: got %b exp 0000", {SRAM_CE, SRAM_OE, SRAM_WE, Mem_Busy}); end
    seen_done = 0;
    repeat (2) begin @(posedge Clk); #1; if (Mem_Done) seen_done = 1; end
    @(negedge Clk); Reset = 1'b0;
    repeat (6) begin @(posedge Clk); #1; if (Mem_Done) seen_done = 1; end
    checks++; if (seen_done !== 1'b0) begin errors++; $display("FAIL rst_mid_no_done: got %b exp 0", seen_done); end
    checks++; if (MDR !== 16'h0) begin errors++; $display("FAIL rst_mid_mdr_after: got %h exp 0000", MDR); end
  endtask

`ifdef MMIO_SW_EN
  task automatic test_mmio;
    SW = 16'h00F0;
    load_mar(16'hFFFF);
    Data_from_SRAM = 16'hDEAD;
    push_exp(16'hFFFF, 16'h00F0, 0, 0, 0);
    access_and_score("mmio_read", 1'b0, 1'b0, '0, 1'b0, '0);
    load_mdr(16'h0F0F);
    push_exp(16'hFFFF, 16'h0F0F, W, 0, W);
    access_and_score("mmio_write", 1'b1, 1'b0, '0, 1'b0, '0);
  endtask
`else
  task automatic test_ffff_plain;
    load_mar(16'hFFFF);
    Data_from_SRAM = 16'h5A5A;
    push_exp(16'hFFFF, 16'h5A5A, W, W, 0);
    access_and_score("ffff_read", 1'b0, 1'b0, '0, 1'b0, '0);
  endtask
`endif

  initial begin
    test_reset();
    test_read();
    test_write();
    test_busy_ldmar();
    test_done_ignores_req();
    test_back_to_back();
`ifdef MMIO_SW_EN
    test_mmio();
`else
    test_ffff_plain();
`endif
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
